// File: rtl/spi_register_sequencer.sv
// spi_register_sequencer: turns register read/write commands into single-cycle SPI master requests, spaced by a guard interval.
module spi_register_sequencer #(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6,
  parameter int ADDR_WIDTH            = 7,
  parameter int REG_WIDTH             = 16,
  parameter int GAP_WIDTH             = 16
) (
  input  logic                             fabric_clk,
  input  logic                             reset_n,
  input  logic [GAP_WIDTH-1:0]             gap_cycles,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_rw,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [REG_WIDTH-1:0]             cmd_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ADDR_WIDTH-1:0]            rsp_addr,
  output logic [REG_WIDTH-1:0]             rsp_data,
  output logic                             busy,
  output logic [15:0]                      txn_count,
  output logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
  output logic [DATA_WIDTH-1:0]            transaction_data,
  output logic [DATA_WIDTH-1:0]            transaction_rw_mask,
  input  logic [DATA_WIDTH-1:0]            transaction_read_data
);
  localparam int L = 1 + ADDR_WIDTH + REG_WIDTH;
  localparam int P = DATA_WIDTH - L;
  localparam logic [DATA_WIDTH-1:0] ONES  = '1;
  localparam logic [DATA_WIDTH-1:0] WMASK = ~(ONES >> L);
  localparam logic [DATA_WIDTH-1:0] RMASK = ~(ONES >> (1 + ADDR_WIDTH));

  if (L > DATA_WIDTH || L >= 2 ** TRANSACTION_LEN_WIDTH) begin : g_bad_params
    $error("spi_register_sequencer: frame length %0d does not fit the master", L);
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d, mask_q, mask_d;
  logic                   rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, rsp_addr_q, rsp_addr_d;
  logic [REG_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [15:0]            txn_q, txn_d;
  logic [L-1:0]           frame;
  logic                   unused_rd;

  assign unused_rd = ^transaction_read_data[DATA_WIDTH-1:REG_WIDTH];

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mask_d     = mask_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    gap_d      = gap_q;
    txn_d      = txn_q;
    frame      = {cmd_rw, cmd_addr, cmd_wdata & {REG_WIDTH{~cmd_rw}}};
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        data_d  = DATA_WIDTH'(frame) << P;
        mask_d  = cmd_rw ? RMASK : WMASK;
        rw_d    = cmd_rw;
        addr_d  = cmd_addr;
        gap_d   = (gap_cycles == '0) ? GAP_WIDTH'(1) : gap_cycles;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        txn_d   = txn_q + 16'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        gap_d = gap_q - GAP_WIDTH'(1);
        if (gap_q == GAP_WIDTH'(1)) begin
          state_d = rw_q ? S_RESP : S_IDLE;
          if (rw_q) begin
            rsp_data_d = transaction_read_data[REG_WIDTH-1:0];
            rsp_addr_d = addr_q;
          end
        end
      end
      S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      mask_q     <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      gap_q      <= '0;
      txn_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
      gap_q      <= gap_d;
      txn_q      <= txn_d;
    end
  end

  assign cmd_ready           = state_q == S_IDLE;
  assign busy                = state_q != S_IDLE;
  assign rsp_valid           = state_q == S_RESP;
  assign rsp_addr            = rsp_addr_q;
  assign rsp_data            = rsp_data_q;
  assign txn_count           = txn_q;
  assign transaction_length  = (state_q == S_ISSUE) ? TRANSACTION_LEN_WIDTH'(L) : '0;
  assign transaction_data    = data_q;
  assign transaction_rw_mask = mask_q;
endmodule

// File: tb/tb_spi_register_sequencer.sv
// tb_spi_register_sequencer: directed stimulus checked every cycle against a timeline model of the sequencer.
module tb_spi_register_sequencer;
  logic        fabric_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] gap_cycles = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [6:0]  rsp_addr;
  logic [15:0] rsp_data;
  logic        busy;
  logic [15:0] txn_count;
  logic [5:0]  transaction_length;
  logic [31:0] transaction_data;
  logic [31:0] transaction_rw_mask;
  logic [31:0] transaction_read_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  spi_register_sequencer dut (
    .fabric_clk(fabric_clk), .reset_n(reset_n), .gap_cycles(gap_cycles),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .busy(busy), .txn_count(txn_count), .transaction_length(transaction_length),
    .transaction_data(transaction_data), .transaction_rw_mask(transaction_rw_mask),
    .transaction_read_data(transaction_read_data)
  );

  always #5 fabric_clk = ~fabric_clk;

  // Model: m_t counts cycles since accept; a transaction occupies cycles 1..G+1.
  bit          m_act = 1'b0, m_pend = 1'b0, m_rw = 1'b0;
  int          m_t = 0, m_g = 0;
  logic [6:0]  m_a = '0, m_ra = '0;
  logic [15:0] m_rd = '0, m_cnt = '0;
  logic [31:0] m_data = '0, m_mask = '0;

  always @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 1'b0; m_pend <= 1'b0; m_t <= 0; m_g <= 0;
      m_data <= '0; m_mask <= '0; m_rd <= '0; m_ra <= '0; m_cnt <= '0;
    end else if (m_act) begin
      if (m_t == 1) m_cnt <= m_cnt + 16'd1;
      if (m_t == m_g + 1) begin
        m_act <= 1'b0;
        if (m_rw) begin
          m_pend <= 1'b1;
          m_rd   <= transaction_read_data[15:0];
          m_ra   <= m_a;
        end
      end else m_t <= m_t + 1;
    end else if (m_pend) begin
      if (rsp_ready) m_pend <= 1'b0;
    end else if (cmd_valid) begin
      m_act  <= 1'b1;
      m_t    <= 1;
      m_g    <= (gap_cycles == 0) ? 1 : int'(gap_cycles);
      m_rw   <= cmd_rw;
      m_a    <= cmd_addr;
      m_data <= (32'(cmd_rw) << 31) | (32'(cmd_addr) << 24) | (cmd_rw ? 32'd0 : 32'(cmd_wdata) << 8);
      m_mask <= cmd_rw ? 32'hFF00_0000 : 32'hFFFF_FF00;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge fabric_clk) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_act && !m_pend));
    chk("busy", 32'(busy), 32'(m_act || m_pend));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    chk("length", 32'(transaction_length), (m_act && m_t == 1) ? 32'd24 : 32'd0);
    chk("data", transaction_data, m_data);
    chk("mask", transaction_rw_mask, m_mask);
    chk("rsp_data", 32'(rsp_data), 32'(m_rd));
    chk("rsp_addr", 32'(rsp_addr), 32'(m_ra));
    chk("txn_count", 32'(txn_count), 32'(m_cnt));
  end

  task automatic send(input logic rw, input logic [6:0] a, input logic [15:0] wd, input logic [15:0] g);
    cmd_rw = rw; cmd_addr = a; cmd_wdata = wd; gap_cycles = g; cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge fabric_clk);
      if (cmd_ready) begin
        #1 cmd_valid = 1'b0;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL accept_timeout: command not accepted within 100 cycles at %0t", $time);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge fabric_clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txn_count", 32'(txn_count), 32'd0);
    reset_n = 1'b1;
    @(posedge fabric_clk); #1;

    send(1'b0, 7'h05, 16'hBEEF, 16'd10);
    for (int k = 1; k <= 12; k++) begin
      @(negedge fabric_clk);
      if (k == 1) begin
        chk("w_len", 32'(transaction_length), 32'd24);
        chk("w_data", transaction_data, 32'h05BE_EF00);
        chk("w_mask", transaction_rw_mask, 32'hFFFF_FF00);
      end
      chk("w_cmd_ready", 32'(cmd_ready), 32'(k == 12));
    end
    chk("w_txn_count", 32'(txn_count), 32'd1);

    transaction_read_data = 32'h0000_A5C3;
    send(1'b1, 7'h12, 16'hFFFF, 16'd4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge fabric_clk);
      if (k == 1) begin
        chk("r_data", transaction_data, 32'h9200_0000);
        chk("r_mask", transaction_rw_mask, 32'hFF00_0000);
      end
      chk("r_rsp_valid", 32'(rsp_valid), 32'(k == 6));
    end
    chk("r_rsp_data", 32'(rsp_data), 32'h0000_A5C3);
    chk("r_rsp_addr", 32'(rsp_addr), 32'h12);
    rsp_ready = 1'b1;
    @(posedge fabric_clk); #1 rsp_ready = 1'b0;

    transaction_read_data = 32'h1234_5678;
    send(1'b1, 7'h2A, 16'h0, 16'd2);
    cmd_rw = 1'b0; cmd_addr = 7'h33; cmd_wdata = 16'h1111; gap_cycles = 16'd3; cmd_valid = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge fabric_clk);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    chk("hold_rsp_data", 32'(rsp_data), 32'h5678);
    chk("hold_rsp_addr", 32'(rsp_addr), 32'h2A);
    rsp_ready = 1'b1;
    @(posedge fabric_clk); #1 rsp_ready = 1'b0;
    @(negedge fabric_clk);
    chk("post_rsp_ready", 32'(cmd_ready), 32'd1);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge fabric_clk); #1 cmd_valid = 1'b0;
    @(negedge fabric_clk);
    chk("held_cmd_len", 32'(transaction_length), 32'd24);
    chk("held_cmd_data", transaction_data, 32'h3311_1100);
    repeat (6) @(negedge fabric_clk);

    send(1'b0, 7'h01, 16'h0002, 16'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge fabric_clk);
      if (k == 1) chk("g0_len", 32'(transaction_length), 32'd24);
      chk("g0_cmd_ready", 32'(cmd_ready), 32'(k == 3));
    end
    send(1'b0, 7'h07, 16'h00AA, 16'd5);
    gap_cycles = 16'd1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge fabric_clk);
      chk("gchg_cmd_ready", 32'(cmd_ready), 32'(k == 7));
    end

    transaction_read_data = 32'h0000_7777;
    send(1'b1, 7'h40, 16'h0, 16'd8);
    repeat (3) @(negedge fabric_clk);
    @(posedge fabric_clk); #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_len", 32'(transaction_length), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_txn_count", 32'(txn_count), 32'd0);
    chk("arst_data", transaction_data, 32'd0);
    @(negedge fabric_clk) reset_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge fabric_clk);
      chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    @(posedge fabric_clk); #1;
    for (int i = 0; i < 1000; i++) send(1'b0, 7'(i), 16'(i) ^ 16'h5A5A, 16'd0);
    repeat (5) @(negedge fabric_clk);
    chk("b2b_txn_count", 32'(txn_count), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
